// File: rtl/banco_reg_sb.sv
// Register file with byte-enabled writes, NRD combinational read ports, optional
// write-to-read forwarding and a per-register pending scoreboard with a live count.
module banco_reg_sb #(
  parameter int ANCHO   = 32,
  parameter int N       = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [N-1:0]         addr_rd,
  input  logic [ANCHO-1:0]     data_in,
  input  logic [ANCHO/8-1:0]   be,
  input  logic [NRD*N-1:0]     addr_rs,
  output logic [NRD*ANCHO-1:0] rs,
  output logic [NRD-1:0]       rs_busy,
  input  logic                 res_en,
  input  logic [N-1:0]         res_addr,
  input  logic                 flush,
  output logic [N:0]           n_pend
);

  localparam int NREG = 1 << N;
  localparam int NB   = ANCHO / 8;

  logic [ANCHO-1:0] regs [NREG];
  logic [NREG-1:0]  pend, pend_nxt;
  logic [N:0]       cnt_nxt;
  logic             wr_ok, res_ok, we_live;

  // r0 is hard-wired to zero when ZERO_R0 is set, so it never takes writes or reserves.
  assign wr_ok   = we && !((ZERO_R0 != 0) && (addr_rd == '0));
  assign res_ok  = res_en && !((ZERO_R0 != 0) && (res_addr == '0));
  assign we_live = wr_ok && rst;

  // Order matters: write clears, reserve re-sets (reserve wins), flush overrides both.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pend_nxt = pend;
    if (we)     pend_nxt[addr_rd]  = 1'b0;
    if (res_ok) pend_nxt[res_addr] = 1'b1;
    if (flush)  pend_nxt           = '0;
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{N{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset explicitly because reads must return zero
      // during and after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      pend   <= '0;
      n_pend <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (wr_ok) begin
        for (int j = 0; j < NB; j++) begin
          if (be[j]) regs[addr_rd][j*8 +: 8] <= data_in[j*8 +: 8];
        end
      end
      pend   <= pend_nxt;
      n_pend <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [N-1:0]     a;
    logic [ANCHO-1:0] stored, data;
    logic             is_r0, hit, busy;

    assign a      = addr_rs[k*N +: N];
    assign stored = regs[a];
    assign is_r0  = (ZERO_R0 != 0) && (a == '0);
    assign hit    = (BYPASS != 0) && we_live && (addr_rd == a);

    always_comb begin
      data = stored;
      busy = pend[a];
      if (hit) begin
        busy = 1'b0;
        for (int j = 0; j < NB; j++) begin
          if (be[j]) data[j*8 +: 8] = data_in[j*8 +: 8];
        end
      end
      if (is_r0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rs[k*ANCHO +: ANCHO] = data;
    assign rs_busy[k]           = busy;
  end

endmodule

// File: tb/tb_banco_reg_sb.sv
// Self-checking bench for banco_reg_sb: directed scenarios plus random traffic,
// compared against an array/bitmask reference model of the register file.
module tb_banco_reg_sb;

  localparam int ANCHO = 32;
  localparam int N     = 5;
  localparam int NRD   = 2;
  localparam int NREG  = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 we = 1'b0, res_en = 1'b0, flush = 1'b0;
  logic [N-1:0]         addr_rd = '0, res_addr = '0;
  logic [ANCHO-1:0]     data_in = '0;
  logic [3:0]           be = '0;
  logic [NRD*N-1:0]     addr_rs = '0;
  logic [NRD*ANCHO-1:0] rs;
  logic [NRD-1:0]       rs_busy;
  logic [N:0]           n_pend;

  int tests = 0;
  int fails = 0;

  logic [31:0]     mem [NREG];
  logic [NREG-1:0] pend_m;

  banco_reg_sb #(.ANCHO(ANCHO), .N(N), .NRD(NRD), .ZERO_R0(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .addr_rd(addr_rd), .data_in(data_in), .be(be),
    .addr_rs(addr_rs), .rs(rs), .rs_busy(rs_busy), .res_en(res_en),
    .res_addr(res_addr), .flush(flush), .n_pend(n_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (b[j]) m[j*8 +: 8] = 8'hFF;
    return (old & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    pend_m = '0;
  endtask

  // Combinational read expectations for the inputs currently applied.
  task automatic check_reads();
    int a;
    logic [31:0] ed;
    logic eb;
    for (int k = 0; k < NRD; k++) begin
      a  = int'(addr_rs[k*N +: N]);
      ed = mem[a];
      eb = pend_m[a];
      if (we && int'(addr_rd) == a) begin
        ed = merge(mem[a], data_in, be);
        eb = 1'b0;
      end
      if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end
      check($sformatf("rs%0d@r%0d", k, a), 64'(rs[k*ANCHO +: ANCHO]), 64'(ed));
      check($sformatf("busy%0d@r%0d", k, a), 64'(rs_busy[k]), 64'(eb));
    end
  endtask

  // Check reads, clock once, advance the model and check the count.
  task automatic tick();
    #1;
    check_reads();
    @(posedge clk);
    if (flush) begin
      pend_m = '0;
    end else begin
      if (we && addr_rd != 0) pend_m[addr_rd] = 1'b0;
      if (res_en && res_addr != 0) pend_m[res_addr] = 1'b1;
    end
    if (we && addr_rd != 0) mem[addr_rd] = merge(mem[addr_rd], data_in, be);
    #1;
    check("n_pend", 64'(n_pend), 64'($countones(pend_m)));
  endtask

  task automatic idle();
    we = 1'b0; res_en = 1'b0; flush = 1'b0; be = 4'h0;
  endtask

  initial begin
    model_reset();
    #3;
    check("reset_rs", 64'(rs), 64'(0));
    check("reset_busy", 64'(rs_busy), 64'(0));
    check("reset_npend", 64'(n_pend), 64'(0));
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Fill: r_i = 2**i, plus an attempted write to r0.
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; addr_rd = 5'(i); data_in = 32'h1 << i; be = 4'hF;
      tick();
    end
    addr_rd = '0; data_in = 32'hDEADBEEF;
    tick();
    idle();
    for (int i = 0; i < NREG; i++) begin
      addr_rs = {5'(i), 5'(i)};
      #1;
      check_reads();
      check("fill_p1", 64'(rs[ANCHO +: ANCHO]), (i == 0) ? 64'(0) : 64'(32'h1 << i));
    end

    // Byte enables on r5.
    we = 1'b1; addr_rd = 5'd5; data_in = 32'hAABBCCDD; be = 4'hF; tick();
    data_in = 32'h11223344; be = 4'b0101; tick();
    idle(); addr_rs = {5'd5, 5'd5}; #1;
    check("be_r5", 64'(rs[ANCHO-1:0]), 64'(32'hAA22CC44));

    // Same-cycle forwarding.
    we = 1'b1; addr_rd = 5'd7; data_in = 32'h12345678; be = 4'hF; addr_rs = {5'd5, 5'd7};
    #1;
    check("bypass_p0", 64'(rs[ANCHO-1:0]), 64'(32'h12345678));
    tick();
    idle();

    // Scoreboard.
    res_en = 1'b1; res_addr = 5'd3; tick();
    res_addr = 5'd9; tick();
    res_addr = 5'd3; tick();
    check("sb_two", 64'(n_pend), 64'(2));
    res_en = 1'b0; we = 1'b1; addr_rd = 5'd9; data_in = 32'h99; be = 4'hF;
    addr_rs = {5'd3, 5'd9};
    #1;
    check("sb_busy_r9_fwd", 64'(rs_busy[0]), 64'(0));
    tick();
    check("sb_one", 64'(n_pend), 64'(1));
    idle(); #1;
    check("sb_busy_r9", 64'(rs_busy[0]), 64'(0));
    check("sb_busy_r3", 64'(rs_busy[1]), 64'(1));
    we = 1'b1; addr_rd = 5'd3; res_en = 1'b1; res_addr = 5'd3; tick();
    idle(); addr_rs = {5'd3, 5'd3}; #1;
    check("sb_res_wins", 64'(rs_busy), 64'(2'b11));
    check("sb_res_wins_n", 64'(n_pend), 64'(1));

    // r0 reserve, then flush beating a reserve.
    res_en = 1'b1; res_addr = 5'd0; tick();
    check("r0_res", 64'(n_pend), 64'(1));
    res_addr = 5'd1; tick();
    res_addr = 5'd2; tick();
    res_addr = 5'd4; flush = 1'b1; we = 1'b1; addr_rd = 5'd6; be = 4'hF; data_in = 32'h66;
    tick();
    idle();
    check("flush_n", 64'(n_pend), 64'(0));
    for (int i = 0; i < NREG; i += 2) begin
      addr_rs = {5'(i), 5'(i + 1)}; #1;
      check("flush_busy", 64'(rs_busy), 64'(0));
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      we       = 1'($urandom);
      addr_rd  = 5'($urandom);
      data_in  = $urandom;
      be       = 4'($urandom);
      res_en   = 1'($urandom);
      res_addr = 5'($urandom);
      flush    = ($urandom_range(15) == 0);
      addr_rs  = 10'($urandom);
      if ($urandom_range(3) == 0) addr_rs[9:5] = addr_rd;
      tick();
    end

    // Asynchronous reset between edges.
    idle(); flush = 1'b1; tick();
    flush = 1'b0; we = 1'b1; addr_rd = 5'd10; data_in = 32'hCAFEF00D; be = 4'hF; tick();
    we = 1'b0; res_en = 1'b1;
    for (int i = 10; i < 13; i++) begin
      res_addr = 5'(i); tick();
    end
    check("pre_reset_n", 64'(n_pend), 64'(3));
    idle(); we = 1'b1; addr_rd = 5'd10; data_in = 32'h55; be = 4'hF; addr_rs = {5'd11, 5'd10};
    #1 rst = 1'b0;
    #1;
    check("arst_rs", 64'(rs), 64'(0));
    check("arst_busy", 64'(rs_busy), 64'(0));
    check("arst_n", 64'(n_pend), 64'(0));
    model_reset();
    idle();
    #14 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 8; i < 14; i += 2) begin
      addr_rs = {5'(i), 5'(i + 1)}; #1;
      check("post_reset_rs", 64'(rs), 64'(0));
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/banco_reg_sb.md
BANCO_REG_SB -- requirements
Module: banco_reg_sb

Interface
REQ-001 The block SHALL have parameter ANCHO, default 32, data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter N, default 5, address width, giving 2**N registers.
REQ-003 The block SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_R0, default 1; when 1, register 0 reads as zero, ignores writes and is never pending.
REQ-005 The block SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port addr_rd, input, N bits: write address.
REQ-010 The block SHALL have port data_in, input, ANCHO bits: write data.
REQ-011 The block SHALL have port be, input, ANCHO/8 bits: per-byte write enables.
REQ-012 The block SHALL have port addr_rs, input, NRD*N bits: packed read addresses, port k at [k*N +: N].
REQ-013 The block SHALL have port rs, output, NRD*ANCHO bits: packed read data, port k at [k*ANCHO +: ANCHO].
REQ-014 The block SHALL have port rs_busy, output, NRD bits: the pending flag of each read port's register.
REQ-015 The block SHALL have port res_en, input, 1 bit: reserve request, which marks a register as pending.
REQ-016 The block SHALL have port res_addr, input, N bits: reserve address.
REQ-017 The block SHALL have port flush, input, 1 bit: synchronous clear of all pending flags.
REQ-018 The block SHALL have port n_pend, output, N+1 bits: count of pending registers.

Function
REQ-019 Storage SHALL be 2**N x ANCHO flops; on a rising clk edge with we=1, each byte j of register addr_rd SHALL take data_in byte j where be[j]=1, and all other bytes SHALL hold.
REQ-020 With ZERO_R0=1, writes to address 0 SHALL be discarded, and every read port addressing 0 SHALL return 0 with rs_busy=0.
REQ-021 Reads SHALL be combinational with zero-cycle latency: rs[k] SHALL equal the stored register addr_rs[k].
REQ-022 With BYPASS=1, we=1 and addr_rs[k]==addr_rd (and the address not a suppressed r0), rs[k] SHALL show data_in on bytes with be=1 and stored bytes elsewhere; with BYPASS=0, rs[k] SHALL show pre-write data until the edge.
REQ-023 All NRD ports SHALL be independent; any ports may read the same address in the same cycle.
REQ-024 Scoreboard: there SHALL be one pend bit per register, updated on the rising edge.
REQ-025 A write with we=1 SHALL clear pend[addr_rd] regardless of be.
REQ-026 res_en=1 SHALL set pend[res_addr]; with ZERO_R0=1 and res_addr=0, no change SHALL occur.
REQ-027 When a write and a reserve target the same address in the same cycle, the reserve SHALL win and pend SHALL end at 1.
REQ-028 flush=1 SHALL clear all pend bits and SHALL override a same-cycle res_en and write.
REQ-029 A reserve of an already-pending register SHALL leave it pending and SHALL NOT change n_pend.
REQ-030 rs_busy[k] SHALL equal pend[addr_rs[k]], except that with BYPASS=1, it SHALL be 0 when we=1 and addr_rd==addr_rs[k] in the same cycle.
REQ-031 n_pend SHALL be a registered count equal to the population of pend after each edge, and SHALL be updated in the same edge as pend.
REQ-032 n_pend SHALL saturate by construction at 2**N; it SHALL never wrap, and SHALL never exceed 2**N-1 when ZERO_R0=1.

Reset
REQ-033 When rst=0, asynchronously and regardless of clk, all registers SHALL be 0, all pend bits 0 and n_pend 0; rs and rs_busy SHALL follow combinationally, all zero.
REQ-034 Assertion of rst mid-operation SHALL abort any in-flight write or reserve; the first active edge SHALL occur on the rising clk after rst returns high.
REQ-035 While rst=0, inputs SHALL be ignored.

Verification
REQ-036 Fill test: after reset, write 2**i to register i for i=1..31 with be all ones, then read every register on both ports -> each returns 2**i, r0 returns 0.
REQ-037 Byte-enable test: write 32'hAABBCCDD to r5, then write 32'h11223344 with be=4'b0101 -> r5 reads 32'hAA22CC44.
REQ-038 Bypass test: we=1, addr_rd=7, data_in=32'h12345678, addr_rs port 0 = 7, same cycle -> rs port 0 = 32'h12345678 before the edge (BYPASS=1); old value when BYPASS=0.
REQ-039 Scoreboard test: reserve r3, r9, r3 over three cycles -> n_pend=2; write r9 -> n_pend=1 and rs_busy for r9 is 0; write r3 while reserving r3 in the same cycle -> r3 stays pending, n_pend=1.
REQ-040 Flush/r0 test: reserve r0 -> no change; reserve r1 and r2 then flush with res_en=1 on r4 -> n_pend=0 and all rs_busy are 0.
REQ-041 Reset test: with data stored and n_pend=3, pull rst low between clk edges -> rs=0, rs_busy=0, n_pend=0 immediately, without a clk edge.
